// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serializes WIDTH-bit words MSB-first into a sequence detector,
// owns the detector's reset and counts its match pulses with a saturating counter.
module seq_det_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_en,
  output logic             det_reset,
  input  logic             det_out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               word_done_q, word_done_d;
  logic               ser_bit_q, ser_bit_d;
  logic               ser_en_q, ser_en_d;
  logic               det_reset_q, det_reset_d;
  logic               busy_q, busy_d;
  logic               in_ready_c;
  logic               accept_c;

  // Ready in IDLE and on the last bit of a word so words can stream back-to-back.
  assign in_ready_c = !clr && ((state_q == ST_IDLE) ||
                               ((state_q == ST_SHIFT) && (idx_q == '0)));
  assign accept_c   = in_ready_c && in_valid;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    clr_cnt_d   = clr_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    word_done_d = 1'b0;

    if (clr) begin
      // Clear wins over everything, including an in-flight word and a coincident hit.
      state_d   = ST_CLEAR;
      shreg_d   = '0;
      idx_d     = '0;
      clr_cnt_d = 1'b0;
      hit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          hit_cnt_d = '0;
          if (clr_cnt_q) begin
            state_d   = ST_IDLE;
            clr_cnt_d = 1'b0;
          end else begin
            clr_cnt_d = 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept_c) begin
            shreg_d = in_data;
            idx_d   = IDX_LAST;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (idx_q == '0) begin
            word_done_d = 1'b1;
            if (accept_c) begin
              shreg_d = in_data;
              idx_d   = IDX_LAST;
            end else begin
              shreg_d = shreg_q << 1;
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = shreg_q << 1;
            idx_d   = idx_q - IDX_W'(1);
          end
        end
        default: begin
          state_d = ST_CLEAR;
        end
      endcase

      if ((state_q != ST_CLEAR) && det_out && (hit_cnt_q != CNT_MAX)) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
    end

    // Output flops follow the next state so they line up with state_q.
    ser_en_d    = (state_d == ST_SHIFT);
    ser_bit_d   = (state_d == ST_SHIFT) && shreg_d[WIDTH-1];
    det_reset_d = (state_d != ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      shreg_q     <= '0;
      idx_q       <= '0;
      clr_cnt_q   <= 1'b0;
      hit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_en_q    <= 1'b0;
      det_reset_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      clr_cnt_q   <= clr_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      word_done_q <= word_done_d;
      ser_bit_q   <= ser_bit_d;
      ser_en_q    <= ser_en_d;
      det_reset_q <= det_reset_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign ser_bit   = ser_bit_q;
  assign ser_en    = ser_en_q;
  assign det_reset = det_reset_q;
  assign hit_cnt   = hit_cnt_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seq_det_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic det_out = 1'b0;
  logic [WIDTH-1:0] in_data = '0;

  logic       in_ready, ser_bit, ser_en, det_reset, word_done, busy;
  logic [7:0] hit_cnt;
  logic       in_ready2, ser_bit2, ser_en2, det_reset2, word_done2, busy2;
  logic [1:0] hit_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: CLEAR cycles left, bits still to emit, hit counts.
  int clear_left = 2;
  bit mq[$];
  int hit8 = 0;
  int hit2 = 0;
  bit done_m = 1'b0;

  seq_det_ctrl #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_bit(ser_bit), .ser_en(ser_en), .det_reset(det_reset),
    .det_out(det_out), .hit_cnt(hit_cnt), .word_done(word_done), .busy(busy)
  );

  seq_det_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .ser_bit(ser_bit2), .ser_en(ser_en2), .det_reset(det_reset2),
    .det_out(det_out), .hit_cnt(hit_cnt2), .word_done(word_done2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    clear_left = 2;
    mq.delete();
    hit8 = 0;
    hit2 = 0;
    done_m = 1'b0;
  endtask

  task automatic model_step();
    bit shifting;
    bit rdy;
    if (clr) begin
      model_reset();
    end else begin
      shifting = (clear_left == 0) && (mq.size() > 0);
      rdy      = (clear_left == 0) && (mq.size() <= 1);
      done_m   = shifting && (mq.size() == 1);
      if ((clear_left == 0) && det_out) begin
        if (hit8 < 255) hit8++;
        if (hit2 < 3) hit2++;
      end
      if (shifting) void'(mq.pop_front());
      if (rdy && in_valid)
        for (int b = WIDTH - 1; b >= 0; b--) mq.push_back(in_data[b]);
      if (clear_left > 0) clear_left--;
    end
  endtask

  // Compare process: outputs against the model each negedge, then advance the model.
  initial begin
    bit clearing, e_en, e_bit, e_rdy;
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      clearing = (clear_left > 0);
      e_en  = !clearing && (mq.size() > 0);
      e_bit = e_en ? mq[0] : 1'b0;
      e_rdy = !clr && !clearing && (mq.size() <= 1);
      check("m_ser_en",    32'(ser_en),    32'(e_en));
      check("m_ser_bit",   32'(ser_bit),   32'(e_bit));
      check("m_in_ready",  32'(in_ready),  32'(e_rdy));
      check("m_det_reset", 32'(det_reset), 32'(!clearing));
      check("m_busy",      32'(busy),      32'(clearing || (mq.size() > 0)));
      check("m_word_done", 32'(word_done), 32'(done_m));
      check("m_hit_cnt",   32'(hit_cnt),   32'(hit8));
      check("m_hit_cnt2",  32'(hit_cnt2),  32'(hit2));
      check("m_busy2",     32'(busy2),     32'(busy));
      if (reset) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int nlow, nen, run, maxrun, ndone, d1, d2, nclr;
    logic [7:0]  bits8;
    logic [15:0] bits16;
    bit acc_now, first_acc;

    // Reset values while reset is held low.
    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_ser_en",    32'(ser_en),    32'd0);
    check("rst_ser_bit",   32'(ser_bit),   32'd0);
    check("rst_det_reset", 32'(det_reset), 32'd0);
    check("rst_hit_cnt",   32'(hit_cnt),   32'd0);
    check("rst_word_done", 32'(word_done), 32'd0);
    check("rst_busy",      32'(busy),      32'd1);

    // Single word 0xB6 offered right at release.
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hB6;
    nlow = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (!det_reset) nlow++;
    end
    @(negedge clk);
    check("a_idle_ready", 32'(in_ready), 32'd1);
    check("a_clear_cycles", 32'(nlow), 32'd2);
    tick(); in_valid = 1'b0;
    bits8 = '0; nen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ser_en) begin nen++; bits8 = {bits8[6:0], ser_bit}; end
    end
    check("a_en_cycles", 32'(nen), 32'd8);
    check("a_bits", 32'(bits8), 32'hB6);
    @(negedge clk);
    check("a_word_done", 32'(word_done), 32'd1);
    check("a_en_off", 32'(ser_en), 32'd0);
    @(negedge clk);
    check("a_done_once", 32'(word_done), 32'd0);
    check("a_idle_busy", 32'(busy), 32'd0);

    // Back-to-back words 0xB6 then 0x5A.
    tick(); in_valid = 1'b1; in_data = 8'hB6;
    nen = 0; run = 0; maxrun = 0; ndone = 0; d1 = 0; d2 = 0; bits16 = '0; first_acc = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      acc_now = in_ready && in_valid;
      if (ser_en) begin
        nen++; run++; bits16 = {bits16[14:0], ser_bit};
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (word_done) begin
        ndone++;
        if (ndone == 1) d1 = c; else d2 = c;
      end
      tick();
      if (acc_now) begin
        if (first_acc) in_data = 8'h5A; else in_valid = 1'b0;
        first_acc = 1'b0;
      end
    end
    check("b_en_cycles", 32'(nen), 32'd16);
    check("b_contiguous", 32'(maxrun), 32'd16);
    check("b_bits", 32'(bits16), 32'hB65A);
    check("b_done_count", 32'(ndone), 32'd2);
    check("b_done_spacing", 32'(d2 - d1), 32'd8);

    // Three separate hits, then a one-cycle clear with a coincident hit.
    for (int k = 0; k < 6; k++) begin det_out = (k % 2 == 0); tick(); end
    det_out = 1'b0;
    @(negedge clk);
    check("c_hit3", 32'(hit_cnt), 32'd3);
    check("c_hit3_sat", 32'(hit_cnt2), 32'd3);
    tick(); clr = 1'b1; det_out = 1'b1;
    @(negedge clk);
    check("c_ready_in_clr", 32'(in_ready), 32'd0);
    tick(); clr = 1'b0; det_out = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("c_det_reset_low", 32'(det_reset), 32'd0);
      check("c_ready_low", 32'(in_ready), 32'd0);
      check("c_hit_zero", 32'(hit_cnt), 32'd0);
    end
    @(negedge clk);
    check("c_ready_back", 32'(in_ready), 32'd1);
    check("c_det_reset_back", 32'(det_reset), 32'd1);

    // Five hits: wide counter reaches 5, 2-bit counter sticks at 3.
    tick();
    for (int k = 0; k < 10; k++) begin det_out = (k % 2 == 0); tick(); end
    det_out = 1'b0;
    @(negedge clk);
    check("d_hit5", 32'(hit_cnt), 32'd5);
    check("d_sat3", 32'(hit_cnt2), 32'd3);

    // Clear while bit 4 of a word is on the line.
    tick(); in_valid = 1'b1; in_data = 8'hC3;
    @(negedge clk);
    tick(); in_valid = 1'b0;
    repeat (3) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge clk);
    check("e_en_drop", 32'(ser_en), 32'd0);
    nclr = (det_reset == 1'b0) ? 1 : 0;
    ndone = (word_done == 1'b1) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!det_reset) nclr++;
      if (word_done) ndone++;
    end
    check("e_clear_cycles", 32'(nclr), 32'd2);
    check("e_no_done", 32'(ndone), 32'd0);
    check("e_idle", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a word.
    tick(); in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    tick(); in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("f_ser_en", 32'(ser_en), 32'd0);
    check("f_ser_bit", 32'(ser_bit), 32'd0);
    check("f_busy", 32'(busy), 32'd1);
    check("f_det_reset", 32'(det_reset), 32'd0);
    check("f_in_ready", 32'(in_ready), 32'd0);
    check("f_hit_cnt", 32'(hit_cnt), 32'd0);
    tick(); tick();
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (word_done) ndone++;
    end
    check("f_no_done", 32'(ndone), 32'd0);
    check("f_idle", 32'(busy), 32'd0);

    // Randomized traffic with rare clears and resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 599) == 0) reset = 1'b0;
      clr      = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = WIDTH'($urandom);
      det_out  = ($urandom_range(0, 3) == 0);
    end
    tick();
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; det_out = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
